// File: rtl/sim_run_ctrl.sv
// Run controller for the pipelined MIPS core: sequences the core reset, counts RUN cycles,
// detects completion (halt instruction or PC self-loop) or budget exhaustion, then freezes the core.
module sim_run_ctrl #(
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned MAX_CYCLES   = 100000,
    parameter int unsigned HALT_REPEAT  = 3,
    parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF,
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic [31:0]          instr,
    input  logic                 pc_valid,
    output logic                 cpu_reset,
    output logic                 run_en,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic                 done,
    output logic                 timeout,
    output logic [PC_WIDTH-1:0]  final_pc
);

    localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned STAB_W = $clog2(HALT_REPEAT);

    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [STAB_W-1:0]    STAB_LAST = STAB_W'(HALT_REPEAT - 2);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_TOUT = 2'd3
    } state_t;

    state_t                state_r;
    logic [HOLD_W-1:0]     hold_cnt_r;
    logic [STAB_W-1:0]     stable_cnt_r;
    logic [PC_WIDTH-1:0]   last_pc_r;
    logic [CNT_WIDTH-1:0]  cycle_count_r;
    logic                  done_r;
    logic                  timeout_r;
    logic [PC_WIDTH-1:0]   final_pc_r;

    logic                  first_run_s;
    logic                  pc_match_s;
    logic                  halt_s;
    logic                  tout_s;

    // Halt / timeout decode for the current RUN cycle.
    always_comb begin
        first_run_s = 1'b0;
        pc_match_s  = 1'b0;
        halt_s      = 1'b0;
        tout_s      = 1'b0;
        // cycle_count is zero only during the first RUN cycle, where last_pc is stale.
        if (cycle_count_r == {CNT_WIDTH{1'b0}}) begin
            first_run_s = 1'b1;
        end else begin
            first_run_s = 1'b0;
        end
        if (pc_valid && !first_run_s && (pc == last_pc_r)) begin
            pc_match_s = 1'b1;
        end else begin
            pc_match_s = 1'b0;
        end
        if (pc_valid && (instr == HALT_INSTR)) begin
            halt_s = 1'b1;
        end else if (pc_match_s && (stable_cnt_r == STAB_LAST)) begin
            halt_s = 1'b1;
        end else begin
            halt_s = 1'b0;
        end
        if (cycle_count_r == CNT_LAST) begin
            tout_s = 1'b1;
        end else begin
            tout_s = 1'b0;
        end
    end

    // Run sequencer state, counters and sticky status.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state_r       <= ST_RST;
            hold_cnt_r    <= {HOLD_W{1'b0}};
            stable_cnt_r  <= {STAB_W{1'b0}};
            last_pc_r     <= {PC_WIDTH{1'b0}};
            cycle_count_r <= {CNT_WIDTH{1'b0}};
            done_r        <= 1'b0;
            timeout_r     <= 1'b0;
            final_pc_r    <= {PC_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_RST: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_r    <= ST_RUN;
                        hold_cnt_r <= {HOLD_W{1'b0}};
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    cycle_count_r <= cycle_count_r + CNT_WIDTH'(1);
                    if (pc_valid) begin
                        last_pc_r <= pc;
                    end
                    if (pc_match_s) begin
                        stable_cnt_r <= stable_cnt_r + STAB_W'(1);
                    end else begin
                        stable_cnt_r <= {STAB_W{1'b0}};
                    end
                    // Halt takes priority over a coincident timeout.
                    if (halt_s) begin
                        state_r    <= ST_DONE;
                        done_r     <= 1'b1;
                        final_pc_r <= pc;
                    end else if (tout_s) begin
                        state_r    <= ST_TOUT;
                        timeout_r  <= 1'b1;
                        final_pc_r <= pc;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                ST_TOUT: begin
                    state_r <= ST_TOUT;
                end
                default: begin
                    state_r <= ST_RST;
                end
            endcase
        end
    end

    assign cpu_reset   = (state_r == ST_RST);
    assign run_en      = (state_r == ST_RUN);
    assign cycle_count = cycle_count_r;
    assign done        = done_r;
    assign timeout     = timeout_r;
    assign final_pc    = final_pc_r;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: each step queues its expected outputs, which are
// popped and compared one edge later.
module tb_sim_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        restart;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pc_valid;
    logic        cpu_reset;
    logic        run_en;
    logic [31:0] cycle_count;
    logic        done;
    logic        timeout;
    logic [31:0] final_pc;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        string       tag;
        logic        cr;
        logic        re;
        logic [31:0] cnt;
        logic        dn;
        logic        to;
        logic [31:0] fpc;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    sim_run_ctrl #(
        .RESET_CYCLES(4),
        .MAX_CYCLES  (20),
        .HALT_REPEAT (3),
        .HALT_INSTR  (32'hFFFF_FFFF),
        .PC_WIDTH    (32),
        .CNT_WIDTH   (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .restart    (restart),
        .pc         (pc),
        .instr      (instr),
        .pc_valid   (pc_valid),
        .cpu_reset  (cpu_reset),
        .run_en     (run_en),
        .cycle_count(cycle_count),
        .done       (done),
        .timeout    (timeout),
        .final_pc   (final_pc)
    );

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s.%s observed=0x%08h expected=0x%08h", tag, fld, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic rs, input logic v, input logic [31:0] p, input logic [31:0] i);
        reset    = rst;
        restart  = rs;
        pc_valid = v;
        pc       = p;
        instr    = i;
    endtask

    task automatic step(input string tag, input logic cr, input logic re, input logic [31:0] cnt,
                        input logic dn, input logic to, input logic [31:0] fpc);
        exp_t e;
        e.tag = tag; e.cr = cr; e.re = re; e.cnt = cnt; e.dn = dn; e.to = to; e.fpc = fpc;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk(e.tag, "cpu_reset",   {31'd0, cpu_reset}, {31'd0, e.cr});
        chk(e.tag, "run_en",      {31'd0, run_en},    {31'd0, e.re});
        chk(e.tag, "cycle_count", cycle_count,        e.cnt);
        chk(e.tag, "done",        {31'd0, done},      {31'd0, e.dn});
        chk(e.tag, "timeout",     {31'd0, timeout},   {31'd0, e.to});
        chk(e.tag, "final_pc",    final_pc,           e.fpc);
    endtask

    // One RUN cycle that must not end the run.
    task automatic run_step(input string tag, input logic v, input logic [31:0] p, input logic [31:0] i,
                            input logic [31:0] cnt);
        drive(1'b0, 1'b0, v, p, i);
        step(tag, 1'b1 ^ 1'b1, 1'b1, cnt, 1'b0, 1'b0, 32'd0);
    endtask

    // Core reset held for exactly four edges, then RUN with a zero count.
    task automatic hold_seq(input string tag);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(tag, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        end
        step(tag, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    // Ended run: everything frozen regardless of inputs.
    task automatic frozen(input string tag, input int n, input logic [31:0] cnt, input logic dn,
                          input logic to, input logic [31:0] fpc);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b0, 1'b1, $urandom, $urandom);
            step(tag, 1'b0, 1'b0, cnt, dn, to, fpc);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        step("reset0", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        step("reset1", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        hold_seq("hold_after_reset");

        // Halt instruction at the 11th RUN cycle, pc 0x3028.
        for (int k = 0; k < 10; k++) begin
            run_step("halt_instr_run", 1'b1, 32'h3000 + 32'(4 * k), 32'h0000_0020, 32'(k + 1));
        end
        drive(1'b0, 1'b0, 1'b1, 32'h3028, 32'hFFFF_FFFF);
        step("halt_instr_hit", 1'b0, 1'b0, 32'd11, 1'b1, 1'b0, 32'h3028);
        frozen("halt_instr_frozen", 3, 32'd11, 1'b1, 1'b0, 32'h3028);

        // Restart from DONE.
        drive(1'b0, 1'b1, 1'b1, 32'h5555, 32'd0);
        step("restart_done", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        hold_seq("hold_after_restart_done");

        // Self-loop: third identical valid PC halts.
        run_step("selfloop_1", 1'b1, 32'h3010, 32'd0, 32'd1);
        run_step("selfloop_2", 1'b1, 32'h3010, 32'd0, 32'd2);
        drive(1'b0, 1'b0, 1'b1, 32'h3010, 32'd0);
        step("selfloop_hit", 1'b0, 1'b0, 32'd3, 1'b1, 1'b0, 32'h3010);
        frozen("selfloop_frozen", 2, 32'd3, 1'b1, 1'b0, 32'h3010);

        // Self-loop broken by invalid cycles, and an invalid halt word: no halt.
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        step("restart_selfloop", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        hold_seq("hold_gap");
        for (int k = 0; k < 6; k++) begin
            run_step("gap_loop", (k % 2) == 0, 32'h3010, 32'd0, 32'(k + 1));
        end
        run_step("invalid_halt_word", 1'b0, 32'h3010, 32'hFFFF_FFFF, 32'd7);
        run_step("gap_loop_tail", 1'b1, 32'h3010, 32'd0, 32'd8);

        // Timeout with an always-advancing PC.
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        step("restart_tout", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        hold_seq("hold_tout");
        for (int k = 0; k < 19; k++) begin
            run_step("tout_run", 1'b1, 32'h4000 + 32'(4 * k), 32'd0, 32'(k + 1));
        end
        drive(1'b0, 1'b0, 1'b1, 32'h404C, 32'd0);
        step("tout_hit", 1'b0, 1'b0, 32'd20, 1'b0, 1'b1, 32'h404C);
        frozen("tout_frozen", 2, 32'd20, 1'b0, 1'b1, 32'h404C);

        // Reset from TOUT.
        drive(1'b1, 1'b0, 1'b1, 32'h1234, 32'd0);
        step("reset_in_tout", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        hold_seq("hold_after_tout_reset");

        // Halt coinciding with the budget limit: halt wins.
        for (int k = 0; k < 19; k++) begin
            run_step("prio_run", 1'b1, 32'h6000 + 32'(4 * k), 32'd0, 32'(k + 1));
        end
        drive(1'b0, 1'b0, 1'b1, 32'h604C, 32'hFFFF_FFFF);
        step("prio_hit", 1'b0, 1'b0, 32'd20, 1'b1, 1'b0, 32'h604C);

        // Restart mid-run at RUN cycle 7.
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
        step("restart_prio", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        hold_seq("hold_mid");
        for (int k = 0; k < 7; k++) begin
            run_step("mid_run", 1'b1, 32'h7000 + 32'(4 * k), 32'd0, 32'(k + 1));
        end
        drive(1'b0, 1'b1, 1'b1, 32'h701C, 32'd0);
        step("restart_mid_run", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

        // Reset while in RST with hold_cnt=2: hold count restarts from zero.
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step("rst_hold_a", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        step("rst_hold_b", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        step("reset_in_rst", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        hold_seq("hold_after_rst_reset");
        run_step("final_run", 1'b1, 32'h8000, 32'd0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
